stmt_lowerer_rr_arbiter: RTL and testbench

- Round-robin arbiter with hold/timeout control.
- Shares one downstream resource among N requesters, of the kind the statement-lowering tests model as a shared comb datapath.
- Grants are registered.
- A granted requester keeps ownership until it signals done, drops its request, or hits the hold limit.
- Sits in the convert test suite as the first sequential scheduler fixture. It combines an always_ff FSM with case, if-chain and for-loop control in the next-state logic.

---
 rtl/stmt_lowerer_rr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_stmt_lowerer_rr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stmt_lowerer_rr_arbiter.sv
// Purpose : round-robin arbiter sharing one downstream resource among N
//           requesters, with per-ownership hold limit and timeout pulse.
// Latency : request->grant 1 cycle from IDLE; every release costs one idle cycle.
// Backpr. : none; requesters hold req level-high until granted, owner releases
//           by done, by dropping req, or by hitting the hold limit.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   req[N]     level-sensitive requests
//   done[N]    release strobes; only the current owner's bit is honoured
//   gnt[N]     registered one-hot grant, zero when idle
//   gnt_valid  high exactly when gnt is non-zero
//   gnt_id     index of the current owner; holds last value while idle
//   timeout    one-cycle pulse after a hold-limit forced release
module stmt_lowerer_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // N and the last legal hold count expressed at the widths they are compared at.
  localparam logic [IDW:0] N_L       = (IDW+1)'(N);
  localparam logic [7:0]   HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [7:0]     hold_cnt;
  logic [7:0]     hold_nxt;
  logic [IDW-1:0] id_nxt;
  logic           timeout_nxt;
  logic [N-1:0]   gnt_nxt;

  // Winner search and release-pointer arithmetic.
  logic [IDW-1:0] winner;
  logic           found;
  logic [IDW:0]   cand;
  logic [IDW:0]   ptr_inc;
  logic [IDW-1:0] rel_ptr;
  logic           owner_rel;

  //--------------------------------------------------------------------------
  // Round-robin winner: first set request scanning ptr, ptr+1, ... with wrap.
  // The candidate index is formed one bit wider so ptr+i cannot overflow
  // before the modulo-N correction; for non-power-of-two N it stays < N.
  //--------------------------------------------------------------------------
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= N_L) begin
        cand = cand - N_L;
      end
      if (!found && req[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end

  // Pointer after a release: (owner+1) mod N, evaluated in IDW+1 bits so the
  // N-1 -> 0 wrap is a compare against N rather than relying on overflow.
  always_comb begin
    ptr_inc = {1'b0, gnt_id} + (IDW+1)'(1);
    rel_ptr = (ptr_inc == N_L) ? '0 : ptr_inc[IDW-1:0];
  end

  assign owner_rel = done[gnt_id] | ~req[gnt_id];

  //--------------------------------------------------------------------------
  // Next-state logic.
  //--------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    id_nxt      = gnt_id;
    timeout_nxt = 1'b0;

    case (state)
      IDLE: begin
        // done is deliberately not looked at here.
        if (found) begin
          state_nxt = GRANT;
          id_nxt    = winner;
          hold_nxt  = 8'd0;
        end
      end

      GRANT: begin
        // Voluntary release outranks the hold limit, so a done that lands on
        // the last allowed cycle never produces a timeout pulse.
        if (owner_rel) begin
          state_nxt = IDLE;
          ptr_nxt   = rel_ptr;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt   = IDLE;
          ptr_nxt     = rel_ptr;
          timeout_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One-hot grant decoded from the next owner index; zero whenever the next
  // state is IDLE so gnt and gnt_valid stay consistent.
  always_comb begin
    gnt_nxt = '0;
    case (state_nxt)
      GRANT: begin
        for (int i = 0; i < N; i++) begin
          gnt_nxt[i] = (id_nxt == IDW'(i));
        end
      end
      default: begin
        gnt_nxt = '0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // State and registered outputs. Reset wins over any in-flight grant.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= 8'd0;
      gnt_id    <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt_id    <= id_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= (state_nxt == GRANT);
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_stmt_lowerer_rr_arbiter.sv
// Bench for stmt_lowerer_rr_arbiter (N=4, MAX_HOLD=8): directed vector table,
// hand-written multi-cycle sequences, then random traffic against a model.
module tb_stmt_lowerer_rr_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW      = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           timeout;

  stmt_lowerer_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner index (-1 = nobody), cycles owned so far,
  // round-robin start position, last owner id, timeout flag.
  int             m_owner;
  int             m_cnt;
  int             m_ptr;
  logic [IDW-1:0] m_id;
  logic           m_to;

  typedef struct {
    logic           rst;
    logic [N-1:0]   rq;
    logic [N-1:0]   dn;
    logic [N-1:0]   eg;
    logic [IDW-1:0] eid;
    logic           eto;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn,
                              input logic [N-1:0] eg, input logic [IDW-1:0] eid, input logic eto);
    vec_t v;
    v.rst = r; v.rq = rq; v.dn = dn; v.eg = eg; v.eid = eid; v.eto = eto;
    return v;
  endfunction

  task automatic model_update(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
    m_to = 1'b0;
    if (!r) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_id = '0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (rq[c]) begin
          m_owner = c; m_cnt = 1; m_id = IDW'(c);
          break;
        end
      end
    end else if (dn[m_owner] || !rq[m_owner]) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1;
    end else if (m_cnt == MAX_HOLD) begin
      m_to = 1'b1; m_ptr = (m_owner + 1) % N; m_owner = -1;
    end else begin
      m_cnt++;
    end
  endtask

  // Apply inputs for one cycle, advance the model, sample 1 ns after the edge.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
    rst_n = r; req = rq; done = dn;
    model_update(r, rq, dn);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [N-1:0] eg, input logic [IDW-1:0] eid,
                       input logic eto);
    logic ev;
    ev = (eg != '0);
    checks++;
    if ({gnt, gnt_valid, gnt_id, timeout} !== {eg, ev, eid, eto}) begin
      failures++;
      $display("FAIL %s: got gnt=%b vld=%b id=%0d to=%b, want gnt=%b vld=%b id=%0d to=%b",
               name, gnt, gnt_valid, gnt_id, timeout, eg, ev, eid, eto);
    end
  endtask

  task automatic check_model(input string name);
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    check(name, eg, m_id, m_to);
  endtask

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] dn;
    logic         r;

    rst_n = 1'b0; req = '0; done = '0;
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_id = '0; m_to = 1'b0;

    // Reset state.
    step(1'b0, 4'b0000, 4'b1111);
    step(1'b0, 4'b0001, 4'b0000);
    check("reset", 4'b0000, 2'd0, 1'b0);

    // Directed table: inputs held for one cycle, outputs after that edge.
    // single requester, release by done -> ptr=1
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 4'b0000, 2'd0, 0));
    // 0101 held from ptr=1: id2, idle, id0, idle, id2, idle
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 4'b0100, 2'd2, 0));
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 4'b0100, 2'd2, 0));
    tbl.push_back(mk(1, 4'b0101, 4'b0100, 4'b0000, 2'd2, 0));
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 4'b0001, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 4'b0001, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0101, 4'b0001, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 4'b0100, 2'd2, 0));
    tbl.push_back(mk(1, 4'b0101, 4'b0100, 4'b0000, 2'd2, 0));
    // ptr=3, 1001: id3 first, wrap to ptr=0, then id0; release by req drop
    tbl.push_back(mk(1, 4'b1001, 4'b0000, 4'b1000, 2'd3, 0));
    tbl.push_back(mk(1, 4'b1001, 4'b1000, 4'b0000, 2'd3, 0));
    tbl.push_back(mk(1, 4'b1001, 4'b0000, 4'b0001, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0));
    // non-owner done ignored; done in IDLE ignored
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b1110, 4'b0001, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b1110, 4'b0001, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b1110, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b1111, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0010, 4'b1111, 4'b0010, 2'd1, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].rq, tbl[i].dn);
      check($sformatf("vec%0d", i), tbl[i].eg, tbl[i].eid, tbl[i].eto);
      check_model($sformatf("vec%0d_model", i));
    end

    // Timeout: ptr=2 now, req[1] held with no done -> exactly 8 grant cycles.
    for (int k = 0; k < MAX_HOLD; k++) begin
      step(1'b1, 4'b0010, 4'b0000);
      check($sformatf("hold%0d", k), 4'b0010, 2'd1, 1'b0);
    end
    step(1'b1, 4'b0010, 4'b0000);
    check("timeout_pulse", 4'b0000, 2'd1, 1'b1);
    step(1'b1, 4'b0010, 4'b0000);
    check("regrant_after_timeout", 4'b0010, 2'd1, 1'b0);

    // done on the last allowed cycle: release without timeout.
    for (int k = 1; k < MAX_HOLD; k++) begin
      step(1'b1, 4'b0010, 4'b0000);
    end
    check("hold_at_limit", 4'b0010, 2'd1, 1'b0);
    step(1'b1, 4'b0010, 4'b0010);
    check("done_beats_limit", 4'b0000, 2'd1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000);
    check("idle_no_pulse", 4'b0000, 2'd1, 1'b0);

    // Reset mid-grant (ptr=2): grant id2, hold 3 cycles, then reset.
    step(1'b1, 4'b0100, 4'b0000);
    check("pre_reset_grant", 4'b0100, 2'd2, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0100, 4'b0000);
    step(1'b0, 4'b0100, 4'b0000);
    check("reset_mid_grant", 4'b0000, 2'd0, 1'b0);
    // ptr back to 0 means 1010 picks id1, not id3.
    step(1'b1, 4'b1010, 4'b0000);
    check("post_reset_grant", 4'b0010, 2'd1, 1'b0);

    // Random traffic versus the model.
    rq = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = ($urandom_range(0, 299) != 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
        dn[b] = ($urandom_range(0, 11) == 0);
      end
      step(r, rq, dn);
      check_model($sformatf("rand%0d", cyc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
